// File: rtl/mem_1r1w_masked_mbist_if.sv
// Port bundle between the MBIST engine (master) and a 1r1w byte-masked memory wrapper (slave).
interface mem_1r1w_masked_mbist_if #(
  parameter int ADDR_W = 5,
  parameter int WIDTH  = 64,
  parameter int MASK_W = 8
);
  logic [ADDR_W-1:0] R0_addr;
  logic              R0_en;
  logic [WIDTH-1:0]  R0_data;
  logic [ADDR_W-1:0] W0_addr;
  logic              W0_en;
  logic [WIDTH-1:0]  W0_data;
  logic [MASK_W-1:0] W0_mask;

  modport master (
    output R0_addr, R0_en,
    input  R0_data,
    output W0_addr, W0_en, W0_data, W0_mask
  );

  modport slave (
    input  R0_addr, R0_en,
    output R0_data,
    input  W0_addr, W0_en, W0_data, W0_mask
  );
endinterface

// File: rtl/mem_1r1w_masked_mbist.sv
// March C- plus byte-mask BIST engine for a 1r1w masked memory; reports pass or the
// first failing address and march element.
module mem_1r1w_masked_mbist #(
  parameter int ADDR_W = 5,
  parameter int WIDTH  = 64,
  parameter int MASK_W = 8
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    start,
  output logic                    busy,
  output logic                    done,
  output logic                    pass,
  output logic [ADDR_W-1:0]       fail_addr,
  output logic [2:0]              fail_element,
  mem_1r1w_masked_mbist_if.master mem
);
  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DRAIN, ST_DONE} state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;
  localparam logic [WIDTH-1:0]  ALL_ONES  = '1;

  function automatic logic [MASK_W-1:0] odd_byte_mask();
    logic [MASK_W-1:0] m;
    for (int i = 0; i < MASK_W; i++) m[i] = (i % 2 == 1);
    return m;
  endfunction

  function automatic logic [WIDTH-1:0] odd_byte_pattern();
    logic [WIDTH-1:0] p;
    for (int i = 0; i < MASK_W; i++) p[8*i +: 8] = (i % 2 == 1) ? 8'hFF : 8'h00;
    return p;
  endfunction

  localparam logic [MASK_W-1:0] ODD_MASK    = odd_byte_mask();
  localparam logic [WIDTH-1:0]  ODD_PATTERN = odd_byte_pattern();

  state_t            state_q, state_d;
  logic [2:0]        elem_q, elem_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              phase_q, phase_d;
  logic              cmp_valid_q, cmp_valid_d;
  logic [WIDTH-1:0]  cmp_exp_q, cmp_exp_d;
  logic [ADDR_W-1:0] cmp_addr_q, cmp_addr_d;
  logic [2:0]        cmp_elem_q, cmp_elem_d;
  logic              done_q, done_d;
  logic              pass_q, pass_d;
  logic [ADDR_W-1:0] fail_addr_q, fail_addr_d;
  logic [2:0]        fail_elem_q, fail_elem_d;

  logic              elem_rw, elem_down, elem_ro, elem_wo;
  logic              rd_cycle, wr_cycle, step_done, addr_done, mismatch;
  logic [WIDTH-1:0]  rd_exp, wr_data;
  logic [MASK_W-1:0] wr_mask;

  // Element decode: E1-E4 are r,w pairs (phase 0 reads, phase 1 writes), E3/E4 walk down.
  always_comb begin
    elem_rw   = (elem_q >= 3'd1) && (elem_q <= 3'd4);
    elem_down = (elem_q == 3'd3) || (elem_q == 3'd4);
    elem_ro   = (elem_q == 3'd5) || (elem_q == 3'd7);
    elem_wo   = (elem_q == 3'd0) || (elem_q == 3'd6);
    rd_exp    = '0;
    wr_data   = '0;
    wr_mask   = '1;
    case (elem_q)
      3'd2, 3'd4: rd_exp = ALL_ONES;
      3'd7:       rd_exp = ODD_PATTERN;
      default:    rd_exp = '0;
    endcase
    case (elem_q)
      3'd1, 3'd3, 3'd6: wr_data = ALL_ONES;
      default:          wr_data = '0;
    endcase
    if (elem_q == 3'd6) wr_mask = ODD_MASK;
    rd_cycle  = (state_q == ST_RUN) && (elem_ro || (elem_rw && !phase_q));
    wr_cycle  = (state_q == ST_RUN) && (elem_wo || (elem_rw && phase_q));
    step_done = !elem_rw || phase_q;
    addr_done = elem_down ? (addr_q == '0) : (addr_q == LAST_ADDR);
    mismatch  = cmp_valid_q && (mem.R0_data != cmp_exp_q);
  end

  always_comb begin
    state_d     = state_q;
    elem_d      = elem_q;
    addr_d      = addr_q;
    phase_d     = phase_q;
    cmp_valid_d = 1'b0;
    cmp_exp_d   = cmp_exp_q;
    cmp_addr_d  = cmp_addr_q;
    cmp_elem_d  = cmp_elem_q;
    done_d      = done_q;
    pass_d      = pass_q;
    fail_addr_d = fail_addr_q;
    fail_elem_d = fail_elem_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d     = ST_RUN;
          elem_d      = '0;
          addr_d      = '0;
          phase_d     = 1'b0;
          done_d      = 1'b0;
          pass_d      = 1'b0;
          fail_addr_d = '0;
          fail_elem_d = '0;
        end
      end
      ST_RUN: begin
        cmp_valid_d = rd_cycle;
        cmp_exp_d   = rd_exp;
        cmp_addr_d  = addr_q;
        cmp_elem_d  = elem_q;
        if (mismatch) begin
          // The command already on the ports this cycle still lands; nothing follows it.
          state_d     = ST_DONE;
          cmp_valid_d = 1'b0;
          done_d      = 1'b1;
          fail_addr_d = cmp_addr_q;
          fail_elem_d = cmp_elem_q;
        end else if (!step_done) begin
          phase_d = 1'b1;
        end else begin
          phase_d = 1'b0;
          if (!addr_done) begin
            addr_d = elem_down ? addr_q - 1'b1 : addr_q + 1'b1;
          end else if (elem_q == 3'd7) begin
            state_d = ST_DRAIN;
          end else begin
            elem_d = elem_q + 3'd1;
            addr_d = ((elem_q == 3'd2) || (elem_q == 3'd3)) ? LAST_ADDR : '0;
          end
        end
      end
      ST_DRAIN: begin
        state_d = ST_DONE;
        done_d  = 1'b1;
        if (mismatch) begin
          fail_addr_d = cmp_addr_q;
          fail_elem_d = cmp_elem_q;
        end else begin
          pass_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      elem_q      <= '0;
      addr_q      <= '0;
      phase_q     <= 1'b0;
      cmp_valid_q <= 1'b0;
      cmp_exp_q   <= '0;
      cmp_addr_q  <= '0;
      cmp_elem_q  <= '0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      fail_addr_q <= '0;
      fail_elem_q <= '0;
    end else begin
      state_q     <= state_d;
      elem_q      <= elem_d;
      addr_q      <= addr_d;
      phase_q     <= phase_d;
      cmp_valid_q <= cmp_valid_d;
      cmp_exp_q   <= cmp_exp_d;
      cmp_addr_q  <= cmp_addr_d;
      cmp_elem_q  <= cmp_elem_d;
      done_q      <= done_d;
      pass_q      <= pass_d;
      fail_addr_q <= fail_addr_d;
      fail_elem_q <= fail_elem_d;
    end
  end

  // Commands decode straight from the state registers so an asynchronous reset silences them at once.
  assign mem.R0_en   = rd_cycle;
  assign mem.R0_addr = rd_cycle ? addr_q : '0;
  assign mem.W0_en   = wr_cycle;
  assign mem.W0_addr = wr_cycle ? addr_q : '0;
  assign mem.W0_data = wr_cycle ? wr_data : '0;
  assign mem.W0_mask = wr_cycle ? wr_mask : '0;

  assign busy         = (state_q == ST_RUN) || (state_q == ST_DRAIN);
  assign done         = done_q;
  assign pass         = pass_q;
  assign fail_addr    = fail_addr_q;
  assign fail_element = fail_elem_q;
endmodule

// File: tb/tb_mem_1r1w_masked_mbist.sv
// Bench for mem_1r1w_masked_mbist: a faulty-memory model on the ports and a march-level
// reference that predicts the command trace, latency and verdict of every run.
module tb_mem_1r1w_masked_mbist;
  localparam int ADDR_W  = 5;
  localparam int WIDTH   = 64;
  localparam int MASK_W  = 8;
  localparam int DEPTH   = 1 << ADDR_W;
  localparam int TIMEOUT = 1000;
  localparam logic [WIDTH-1:0]  ONES    = '1;
  localparam logic [WIDTH-1:0]  E7_PAT  = 64'hFF00FF00FF00FF00;
  localparam logic [MASK_W-1:0] E6_MASK = 8'hAA;

  typedef struct packed {
    logic              w;
    logic [ADDR_W-1:0] a;
    logic [WIDTH-1:0]  d;
    logic [MASK_W-1:0] m;
  } cmd_t;

  logic              clock = 1'b0;
  logic              reset;
  logic              start;
  logic              busy, done, pass;
  logic [ADDR_W-1:0] fail_addr;
  logic [2:0]        fail_element;

  mem_1r1w_masked_mbist_if #(.ADDR_W(ADDR_W), .WIDTH(WIDTH), .MASK_W(MASK_W)) mem_if ();

  mem_1r1w_masked_mbist #(.ADDR_W(ADDR_W), .WIDTH(WIDTH), .MASK_W(MASK_W)) dut (
    .clock(clock), .reset(reset), .start(start), .busy(busy), .done(done), .pass(pass),
    .fail_addr(fail_addr), .fail_element(fail_element), .mem(mem_if)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_errors = 0;

  // Fault configuration shared by the memory model and the reference.
  bit stuck_en, stuck_val, ignore_mask, cpl_en, scramble;
  int stuck_addr, stuck_bit, cpl_aggr, cpl_vict;

  logic [WIDTH-1:0] mem_arr [DEPTH];
  logic [WIDTH-1:0] ref_arr [DEPTH];

  cmd_t              exp_cmd_q [$];
  logic [ADDR_W+3:0] exp_res_q [$];
  int  exp_latency;
  int  ref_issued, ref_fail_addr, ref_fail_elem;
  bit  ref_failed, ref_halted;
  logic done_prev = 1'b0;

  task automatic check_output(input string name, input logic [127:0] actual, input logic [127:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  function automatic logic [WIDTH-1:0] merge_word(input logic [WIDTH-1:0] old, input logic [WIDTH-1:0] d,
                                                  input logic [MASK_W-1:0] m);
    logic [WIDTH-1:0] bm;
    for (int i = 0; i < MASK_W; i++) bm[8*i +: 8] = {8{m[i]}};
    if (ignore_mask) return d;
    return (old & ~bm) | (d & bm);
  endfunction

  function automatic logic [WIDTH-1:0] read_word(input int a, input logic [WIDTH-1:0] w);
    logic [WIDTH-1:0] r;
    r = w;
    if (stuck_en && a == stuck_addr) r[stuck_bit] = stuck_val;
    return r;
  endfunction

  // Memory model seen by the DUT: registered read, masked write, planted faults.
  always @(posedge clock) begin
    if (scramble) begin
      for (int i = 0; i < DEPTH; i++) mem_arr[i] = {$urandom, $urandom};
    end
    if (mem_if.W0_en) begin
      mem_arr[mem_if.W0_addr] = merge_word(mem_arr[mem_if.W0_addr], mem_if.W0_data, mem_if.W0_mask);
      if (cpl_en && int'(mem_if.W0_addr) == cpl_aggr) mem_arr[cpl_vict] = ~mem_arr[cpl_vict];
    end
    if (mem_if.R0_en) mem_if.R0_data <= read_word(int'(mem_if.R0_addr), mem_arr[mem_if.R0_addr]);
  end

  task automatic ref_issue(input bit w, input int a, input logic [WIDTH-1:0] d, input logic [MASK_W-1:0] m,
                           input int e);
    cmd_t c;
    if (ref_halted) return;
    c.w = w;
    c.a = a[ADDR_W-1:0];
    c.d = w ? d : '0;
    c.m = w ? m : '0;
    exp_cmd_q.push_back(c);
    ref_issued++;
    if (ref_failed) begin
      ref_halted = 1'b1;
      return;
    end
    if (w) begin
      ref_arr[a] = merge_word(ref_arr[a], d, m);
      if (cpl_en && a == cpl_aggr) ref_arr[cpl_vict] = ~ref_arr[cpl_vict];
    end else if (read_word(a, ref_arr[a]) != d) begin
      ref_failed    = 1'b1;
      ref_fail_addr = a;
      ref_fail_elem = e;
      exp_latency   = ref_issued + 1;
    end
  endtask

  // Walks the eight march elements as a list of operations and predicts the DUT's behaviour.
  task automatic run_reference();
    logic [ADDR_W+3:0] res;
    logic [ADDR_W-1:0] fa;
    logic [2:0]        fe;
    ref_issued = 0;
    ref_failed = 1'b0;
    ref_halted = 1'b0;
    for (int i = 0; i < DEPTH; i++) ref_arr[i] = '0;
    for (int e = 0; e < 8; e++) begin
      bit down, rd, wr;
      logic [WIDTH-1:0]  rexp, wdat;
      logic [MASK_W-1:0] wmask;
      down  = (e == 3 || e == 4);
      rd    = (e >= 1 && e <= 5) || e == 7;
      wr    = (e <= 4) || e == 6;
      rexp  = (e == 2 || e == 4) ? ONES : ((e == 7) ? E7_PAT : '0);
      wdat  = (e == 1 || e == 3 || e == 6) ? ONES : '0;
      wmask = (e == 6) ? E6_MASK : '1;
      for (int i = 0; i < DEPTH; i++) begin
        int a;
        a = down ? DEPTH - 1 - i : i;
        if (rd) ref_issue(1'b0, a, rexp, '0, e);
        if (wr) ref_issue(1'b1, a, wdat, wmask, e);
      end
    end
    if (!ref_failed) exp_latency = ref_issued + 1;
    fa  = ref_fail_addr[ADDR_W-1:0];
    fe  = ref_fail_elem[2:0];
    res = ref_failed ? {1'b0, fa, fe} : {1'b1, {ADDR_W{1'b0}}, 3'b000};
    exp_res_q.push_back(res);
  endtask

  // Monitor: pops one expected command per issued command and one verdict per rising done.
  always @(negedge clock) begin
    cmd_t act, exp_c;
    if (!reset) begin
      if (mem_if.R0_en && mem_if.W0_en) check_output("one_port_per_cycle", 128'd1, 128'd0);
      if (mem_if.R0_en || mem_if.W0_en) begin
        act.w = mem_if.W0_en;
        act.a = mem_if.W0_en ? mem_if.W0_addr : mem_if.R0_addr;
        act.d = mem_if.W0_en ? mem_if.W0_data : '0;
        act.m = mem_if.W0_en ? mem_if.W0_mask : '0;
        if (exp_cmd_q.size() == 0) begin
          check_output("unexpected_command", 128'(act), 128'd0);
        end else begin
          exp_c = exp_cmd_q.pop_front();
          check_output("command", 128'(act), 128'(exp_c));
        end
      end
      if (done && !done_prev) begin
        if (exp_res_q.size() == 0) check_output("unexpected_done", 128'd1, 128'd0);
        else check_output("verdict", 128'({pass, fail_addr, fail_element}), 128'(exp_res_q.pop_front()));
      end
    end
    done_prev = done;
  end

  task automatic clear_faults();
    stuck_en    = 1'b0;
    ignore_mask = 1'b0;
    cpl_en      = 1'b0;
  endtask

  task automatic apply_stimulus(input int repulse_at, input int abort_at);
    int edges;
    bit aborted;
    run_reference();
    @(negedge clock) scramble = 1'b1;
    @(negedge clock) scramble = 1'b0;
    repeat ($urandom_range(0, 3)) @(negedge clock);
    start = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0;
    check_output("busy_after_start", 128'(busy), 128'd1);
    check_output("done_cleared", 128'(done), 128'd0);
    edges   = 0;
    aborted = 1'b0;
    while (!done && edges < TIMEOUT) begin
      start = (edges == repulse_at);
      @(posedge clock);
      edges++;
      #1;
      if (edges == abort_at) begin
        reset = 1'b1;
        #1;
        check_output("abort_r0_en", 128'(mem_if.R0_en), 128'd0);
        check_output("abort_w0_en", 128'(mem_if.W0_en), 128'd0);
        check_output("abort_busy", 128'(busy), 128'd0);
        aborted = 1'b1;
        break;
      end
    end
    start = 1'b0;
    if (aborted) begin
      repeat (3) @(negedge clock);
      reset = 1'b0;
      exp_cmd_q.delete();
      exp_res_q.delete();
    end else begin
      check_output("done_latency", 128'(edges), 128'(exp_latency));
      @(negedge clock);
      #1;
      check_output("busy_after_done", 128'(busy), 128'd0);
      check_output("cmds_left", 128'(exp_cmd_q.size()), 128'd0);
      check_output("verdicts_left", 128'(exp_res_q.size()), 128'd0);
    end
  endtask

  initial begin
    reset    = 1'b1;
    start    = 1'b0;
    scramble = 1'b0;
    clear_faults();
    #3;
    check_output("reset_status", 128'({busy, done, pass, fail_addr, fail_element}), 128'd0);
    check_output("reset_ports", 128'({mem_if.R0_en, mem_if.W0_en, mem_if.W0_mask}), 128'd0);
    repeat (2) @(negedge clock);
    reset = 1'b0;

    $display("[TB] fault-free run");
    apply_stimulus(-1, -1);

    $display("[TB] stuck-at-0 bit 3 of address 17");
    stuck_en = 1'b1; stuck_addr = 17; stuck_bit = 3; stuck_val = 1'b0;
    apply_stimulus(-1, -1);
    for (int k = 0; k < 3; k++) begin
      stuck_addr = $urandom_range(0, DEPTH - 1);
      stuck_bit  = $urandom_range(0, WIDTH - 1);
      stuck_val  = 1'($urandom_range(0, 1));
      $display("[TB] random stuck-at: addr %0d bit %0d value %0d", stuck_addr, stuck_bit, stuck_val);
      apply_stimulus(-1, -1);
    end
    clear_faults();

    $display("[TB] memory ignores byte mask");
    ignore_mask = 1'b1;
    apply_stimulus(-1, -1);
    clear_faults();

    $display("[TB] coupling fault: write to 9 inverts 10");
    cpl_en = 1'b1; cpl_aggr = 9; cpl_vict = 10;
    apply_stimulus(-1, -1);
    for (int k = 0; k < 2; k++) begin
      cpl_aggr = $urandom_range(0, DEPTH - 1);
      cpl_vict = (cpl_aggr + $urandom_range(1, DEPTH - 1)) % DEPTH;
      $display("[TB] random coupling: aggressor %0d victim %0d", cpl_aggr, cpl_vict);
      apply_stimulus(-1, -1);
    end
    clear_faults();

    $display("[TB] start re-pulsed mid-run");
    apply_stimulus(100, -1);

    $display("[TB] reset asserted mid-run, then a clean run");
    apply_stimulus(-1, 200);
    check_output("post_abort_done", 128'(done), 128'd0);
    apply_stimulus(-1, -1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
